// File: rtl/pwm_compare_pkg.sv
// Shared definitions for the PWM compare block: default widths, reset duty
// and the FSM encoding (ST_RUN is also used by the bench for state probes).
package pwm_compare_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DUTY_RST_DEF = 128;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_compare_if.sv
// Duty-update handshake between a duty producer (master) and the PWM block (slave).
interface pwm_compare_if
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/pwm_compare_duty_shadow.sv
// Double-buffered duty register. A request is parked in the pending slot and
// only moves to the active duty on an enabled wrap, so a period never changes
// its duty half way through. A request arriving on the wrap itself bypasses
// the pending slot.
module pwm_compare_duty_shadow
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DUTY_RST = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             wrap_en,
  // Duty that governs the count sampled this cycle; equals the stored active
  // duty except on an enabled wrap, where it is the value being installed.
  output logic [WIDTH-1:0] active_duty
);

  logic [WIDTH-1:0] active_reg;
  logic [WIDTH-1:0] pending_reg;
  logic             pending_full_reg;
  logic             accept;

  assign duty_ready = !pending_full_reg;
  assign accept     = duty_valid && duty_ready;

  // Select the duty in force for this cycle, including the wrap-time transfer.
  always_comb begin
    active_duty = active_reg;
    if (wrap_en) begin
      if (accept) begin
        active_duty = duty_in;
      end else if (pending_full_reg) begin
        active_duty = pending_reg;
      end
    end
  end

  // Pending/active storage; a wrap always leaves the pending slot empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_reg       <= WIDTH'(DUTY_RST);
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
    end else begin
      active_reg <= active_duty;
      if (wrap_en) begin
        pending_full_reg <= 1'b0;
      end else if (accept) begin
        pending_reg      <= duty_in;
        pending_full_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_compare.sv
// PWM generator driven by an external free-running counter. Produces one PWM
// period per counter wrap, checks that the count advances by exactly one each
// cycle and drops to a safe (pwm low) state when it does not.
module pwm_compare
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DUTY_RST = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] count,
  pwm_compare_if.slave     duty_bus,
  input  logic             err_clr,
  output logic             pwm,
  output logic             period_start,
  output logic             seq_err
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] cmp_duty;
  logic             wrap;
  logic             step_err;
  logic             wrap_en;

  assign wrap     = (count == '0);
  assign prev_inc = prev_reg + {{(WIDTH-1){1'b0}}, 1'b1};
  assign step_err = (state_reg == ST_RUN) && (count != prev_inc);
  // Duty transfers only on wraps that leave the FSM in RUN, which also covers
  // the wrap that takes SYNC into RUN.
  assign wrap_en  = wrap && (state_next == ST_RUN);

  // Next-state decode for the sync/run/fault controller.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SYNC:  if (wrap)     state_next = ST_RUN;
      ST_RUN:   if (step_err) state_next = ST_FAULT;
      ST_FAULT: if (err_clr)  state_next = ST_SYNC;
      default:                state_next = ST_SYNC;
    endcase
  end

  pwm_compare_duty_shadow #(
    .WIDTH    (WIDTH),
    .DUTY_RST (DUTY_RST)
  ) u_duty_shadow (
    .clk         (clk),
    .rstn        (rstn),
    .duty_in     (duty_bus.duty_in),
    .duty_valid  (duty_bus.duty_valid),
    .duty_ready  (duty_bus.duty_ready),
    .wrap_en     (wrap_en),
    .active_duty (cmp_duty)
  );

  // FSM state, previous count and registered outputs; a new error beats err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_SYNC;
      prev_reg     <= '0;
      pwm          <= 1'b0;
      period_start <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_reg     <= count;
      pwm          <= (state_next == ST_RUN) && (count < cmp_duty);
      period_start <= wrap;
      if (step_err) begin
        seq_err <= 1'b1;
      end else if (err_clr) begin
        seq_err <= 1'b0;
      end
    end
  end

endmodule
